uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Round-robin arbiter sharing one UART transmitter (8N1, 115200 baud at the 125 MHz clk, 1085 clk/bit) among NREQ on-chip requesters.
- Grants are packet-locked: a requester keeps the transmitter until it hands over a byte flagged last, so multi-byte messages are never interleaved.
- Sits in top between the message sources (LED/status reporter, command-response logic, debug dump) and the UART TX core that drives uart_txo.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT, 4096, idle-lock watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock, 125 MHz.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req_valid  input  NREQ  per-requester byte valid.
- req_data  input  NREQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NREQ  byte is the final byte of the packet.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- tx_valid  output  1  byte valid to the UART TX core.
- tx_data  output  DATA_W  byte to the UART TX core.
- tx_ready  input  1  UART TX core can accept a byte.
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  a grant is held (state XFER).

Behaviour:
- Reset values: state IDLE, rr_ptr = NREQ-1 (requester 0 has first priority), grant_id 0, busy 0, tx_valid 0, tx_data 0, all req_ready 0.
- Asserting reset mid-transfer clears everything asynchronously. An un-handshaked byte is dropped. A byte already taken by the TX core still completes on the line.
- States:
  - IDLE: tx_valid = 0, req_ready = 0. If any req_valid is set, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... with modulo-NREQ wrap. Register it into grant_id, set busy, go to XFER on the next edge. Arbitration latency is 1 cycle: a request seen in cycle N can handshake in cycle N+1 at the earliest. If no request, stay in IDLE.
  - XFER: tx_valid = req_valid[grant_id] and tx_data = req_data[grant_id], both combinational passthrough. req_ready[grant_id] = tx_ready; every other req_ready bit is 0.
    - Handshake = tx_valid & tx_ready.
    - Handshake with req_last[grant_id] = 1: rr_ptr <= grant_id, busy <= 0, go to IDLE.
    - Handshake with req_last = 0: stay in XFER.
- Returning through IDLE costs 1 bubble cycle between packets. This has no throughput impact, since one UART byte takes 10850 cycles.
- Requests from non-granted requesters during XFER are ignored and see no ready until re-arbitration.
- A granted requester that deasserts req_valid mid-packet keeps the lock (tx_valid follows it low).
- Requesters must hold valid, data and last stable until ready; the arbiter does not re-check this.
- grant_id holds its value in IDLE until the next grant.
- A single-byte packet (last on the first byte) is legal: IDLE→XFER→IDLE.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,…,NREQ-1,0.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every handshake and on entry to XFER, and increments each XFER cycle in which req_valid[grant_id] = 0.
  - When the count reaches TIMEOUT, the lock is released: rr_ptr <= grant_id, go to IDLE, assert timeout_flag for 1 cycle.
  - timeout_flag is an extra output, 1 bit, reset value 0.
  - The abandoned requester must restart its packet.
- Undefined: no counter, no timeout_flag port, and the lock is held indefinitely.

Test Plan:
- Reset, then a single requester: req 2 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), with tx_ready pulsed once per 10850 cycles. Expect tx_data order 41,42,43; grant_id = 2; busy high from cycle+1 until the edge after the 0x43 handshake.
- All 4 requesters each send 1-byte packets continuously with tx_ready = 1. Expect grant order 0,1,2,3,0 and exactly 1 idle cycle between handshakes.
- Interleave check: req 0 sends a 4-byte packet while req 1 asserts valid from cycle 2. Expect req_ready[1] = 0 until req 0's last byte; the next grant goes to 1.
- tx_ready held 0 for 500 cycles while in XFER. Expect tx_valid = 1 and tx_data stable, with no req_ready asserted.
- Reset asserted (0) in XFER mid-packet. Expect tx_valid, busy and req_ready to be 0 immediately (asynchronously), and after release requester 0 has top priority.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT = 16: req 3 sends one non-last byte, then drops valid. Expect timeout_flag pulse 16 cycles later, return to IDLE, and a pending req 0 granted next.

Source files
------------

// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arb - packet-locked round-robin arbiter for one shared UART TX   |
// | Rev 1.0 | optional idle-lock watchdog: UART_TX_ARB_TIMEOUT_EN           |
// +--------------------------------------------------------------------------+
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_flag
`endif
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   rr_ptr_n;
  logic [GW-1:0]   grant_n;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   pick;
  logic            any_req;
  logic            grant_valid;
  logic            grant_last;
  logic            handshake;
  logic            tmo_hit;

  if (NREQ < 2 || NREQ > 8 || DATA_W < 1 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arb: parameter out of range");
  end

  // Scan downward so the requester closest after rr_ptr is the last to win.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  assign grant_valid = req_valid[grant_id];
  assign grant_last  = req_last[grant_id];
  assign handshake   = (state == XFER) && grant_valid && tx_ready;
  assign busy        = (state == XFER);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;

  assign tmo_hit = (state == XFER) && !grant_valid && (idle_cnt == CW'(TIMEOUT - 1));

  // Counter is held at zero in IDLE, so it starts clean on entry to XFER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= tmo_hit;
      if (state == IDLE || handshake || tmo_hit) begin
        idle_cnt <= '0;
      end else if (!grant_valid) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    grant_n   = grant_id;
    rr_ptr_n  = rr_ptr;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n = pick;
          state_n = XFER;
        end
      end
      XFER: begin
        tx_valid            = grant_valid;
        tx_data             = req_data[grant_id*DATA_W +: DATA_W];
        req_ready[grant_id] = tx_ready;
        if ((handshake && grant_last) || tmo_hit) begin
          rr_ptr_n = grant_id;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= GW'(NREQ - 1);
      grant_id <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      grant_id <= grant_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_tx_arb - scoreboard bench: bytes expected in arbitration order, checked at each TX handshake.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMO  = 16;
`else
  localparam int TMO  = 4096;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_valid;
  logic [DW-1:0]        tx_data;
  logic                 tx_ready;
  logic [1:0]           grant_id;
  logic                 busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic                 timeout_flag;
`endif

  uart_tx_arb #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
`ifdef UART_TX_ARB_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .busy      (busy)
  );

  always #4 clk = ~clk;

  int              checks   = 0;
  int              failures = 0;
  int              cyc      = 0;
  int              last_hs_cyc = 0;
  int              hs_cnt   = 0;
  bit              chk_gap  = 0;
  bit              have_prev = 0;
  logic [8:0]      src_q [NREQ][$];   // {last, data} per requester
  logic [9:0]      exp_q [$];         // {requester, data} in expected line order
  logic [NREQ-1:0] src_en  = '1;
  logic [NREQ-1:0] hs_seen = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [3:0] one;
    hs_seen = req_valid & req_ready;
    if (reset && tx_valid && tx_ready) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        one = 4'b0001 << e[9:8];
        check_val("hs_grant", 32'(grant_id), 32'(e[9:8]));
        check_val("hs_data", 32'(tx_data), 32'(e[7:0]));
        check_val("hs_ready", 32'(req_ready), 32'(one));
      end
      if (chk_gap && have_prev) check_val("hs_gap", 32'(cyc - last_hs_cyc), 32'd2);
      last_hs_cyc = cyc;
      have_prev   = 1;
      hs_cnt++;
    end
  end

  // Requester models: present queue head, pop it after an accepted handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_en[i] && src_q[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][7:0];
          req_last[i]          = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      hs_seen = '0;
    end
  end

  task automatic src_push(input int r, input logic [7:0] d, input bit last);
    src_q[r].push_back({last, d});
  endtask

  task automatic exp_push(input int r, input logic [7:0] d);
    exp_q.push_back({2'(r), d});
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    hs_seen   = '0;
    chk_gap   = 0;
    have_prev = 0;
    src_en    = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b0;
    tx_ready = 1'b0;
    clear_all();
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int h0;
    reset     = 1'b0;
    tx_ready  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_grant", 32'(grant_id), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);

    // Single requester, tx_ready pulsed once per UART byte time
    do_reset();
    src_push(2, 8'h41, 0); exp_push(2, 8'h41);
    src_push(2, 8'h42, 0); exp_push(2, 8'h42);
    src_push(2, 8'h43, 1); exp_push(2, 8'h43);
    repeat (2) @(negedge clk);
    #1;
    check_val("t1_busy_on", 32'(busy), 32'd1);
    check_val("t1_grant", 32'(grant_id), 32'd2);
    check_val("t1_tx_valid", 32'(tx_valid), 32'd1);
    check_val("t1_first_data", 32'(tx_data), 32'h41);
    for (int b = 0; b < 3; b++) begin
      repeat (10849) @(posedge clk);
      #1;
      tx_ready = 1'b1;
      @(negedge clk);
      check_val("t1_busy_held", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
    end
    @(negedge clk);
    check_val("t1_busy_off", 32'(busy), 32'd0);
    check_val("t1_grant_hold", 32'(grant_id), 32'd2);
    drain(4, "t1");

    // All four requesters streaming 1-byte packets: strict rotation, one bubble
    do_reset();
    tx_ready = 1'b1;
    chk_gap  = 1;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < NREQ; r++) begin
        src_push(r, 8'(8'h10 * r + p), 1);
        exp_push(r, 8'(8'h10 * r + p));
      end
    end
    drain(100, "t2");
    chk_gap = 0;

    // No interleave: requester 1 waits for requester 0's whole packet
    do_reset();
    tx_ready  = 1'b1;
    src_en[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      src_push(0, 8'(8'hA0 + b), b == 3);
      exp_push(0, 8'(8'hA0 + b));
    end
    src_push(1, 8'hB0, 1);
    exp_push(1, 8'hB0);
    repeat (2) @(negedge clk);
    #1;
    src_en[1] = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (busy && grant_id == 2'd0 && req_ready[1]) bad++;
    end
    check_val("t3_no_ready_1", 32'(bad), 32'd0);
    drain(20, "t3");

    // Long stall: data held, no ready
    do_reset();
    src_push(1, 8'h5A, 0); exp_push(1, 8'h5A);
    src_push(1, 8'h5B, 1); exp_push(1, 8'h5B);
    repeat (3) @(negedge clk);
    #1;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A || req_ready !== '0 || busy !== 1'b1) bad++;
    end
    check_val("t4_stall_bad", 32'(bad), 32'd0);
    check_val("t4_stall_data", 32'(tx_data), 32'h5A);
    tx_ready = 1'b1;
    drain(20, "t4");

    // Asynchronous reset mid-packet, then requester 0 first again
    do_reset();
    src_push(2, 8'h77, 0);
    src_push(2, 8'h78, 1);
    repeat (3) @(negedge clk);
    #1;
    check_val("t5_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("t5_async_tx_valid", 32'(tx_valid), 32'd0);
    check_val("t5_async_busy", 32'(busy), 32'd0);
    check_val("t5_async_ready", 32'(req_ready), 32'd0);
    check_val("t5_async_grant", 32'(grant_id), 32'd0);
    clear_all();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    src_push(2, 8'h99, 1);
    src_push(0, 8'h11, 1);
    exp_push(0, 8'h11);
    exp_push(2, 8'h99);
    tx_ready = 1'b1;
    drain(20, "t5");

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog releases an abandoned lock
    do_reset();
    tx_ready = 1'b1;
    h0 = hs_cnt;
    src_push(3, 8'hC3, 0); exp_push(3, 8'hC3);
    n = 0;
    while (hs_cnt == h0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("t6_first_hs", 32'(hs_cnt - h0), 32'd1);
    src_push(0, 8'h01, 1); exp_push(0, 8'h01);
    n = 0;
    while (timeout_flag !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("t6_tmo_delay", 32'(cyc - last_hs_cyc - 1), 32'd16);
    check_val("t6_tmo_idle", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check_val("t6_tmo_pulse", 32'(timeout_flag), 32'd0);
    drain(20, "t6");
`else
    n  = 0;
    h0 = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
